// File: rtl/gates_bist_ctrl.sv
// gates_bist_ctrl: truth-table self-test sequencer for the two-input gate block.
// Ports: clk, rst_n, start in; input1/input2 drive out; seven gate outputs in;
// busy, done, pass, err_count, fail_vec status out.
module gates_bist_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             input1,
  output logic             input2,
  input  logic             inv1,
  input  logic             and2,
  input  logic             or2,
  input  logic             xor2,
  input  logic             xnor2,
  input  logic             nand2,
  input  logic             nor2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = CNT_W + 3;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [HW-1:0]    hold_cnt, hold_nx;
  logic [1:0]       vec_idx, vec_nx;
  logic [CNT_W-1:0] err_nx, err_sat;
  logic [3:0]       fv_nx;
  logic             pass_nx;
  logic             in1_nx, in2_nx;
  logic [6:0]       gold, obs, miss;
  logic [2:0]       mism;
  logic [SW-1:0]    sum;
  logic             last;

  assign obs = {inv1, and2, or2, xor2, xnor2, nand2, nor2};

  // Golden values follow the driven registers, which always equal vec_idx.
  assign gold = {
    ~input1,
    input1 & input2,
    input1 | input2,
    input1 ^ input2,
    ~(input1 ^ input2),
    ~(input1 & input2),
    ~(input1 | input2)
  };

  // Case inequality so an X/Z on a gate output counts as a mismatch.
  always_comb begin
    miss = '0;
    mism = '0;
    for (int i = 0; i < 7; i++) begin
      miss[i] = !(obs[i] === gold[i]);
      mism = mism + 3'(miss[i]);
    end
  end

  // Saturating accumulate: the extra 3 bits absorb one compare's worth.
  always_comb begin
    sum = SW'(err_count) + SW'(mism);
    err_sat = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  assign last = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nx = state;
    hold_nx = hold_cnt;
    vec_nx = vec_idx;
    err_nx = err_count;
    fv_nx = fail_vec;
    pass_nx = pass;
    in1_nx = input1;
    in2_nx = input2;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          hold_nx = '0;
          vec_nx = '0;
          err_nx = '0;
          fv_nx = '0;
          pass_nx = 1'b0;
          in1_nx = 1'b0;
          in2_nx = 1'b0;
        end
      end
      RUN: begin
        if (last) begin
          err_nx = err_sat;
          if (mism != 3'd0) fv_nx[vec_idx] = 1'b1;
          if (vec_idx == 2'd3) begin
            state_nx = DONE;
            pass_nx = (err_sat == '0);
          end else begin
            vec_nx = vec_idx + 2'd1;
            hold_nx = '0;
            {in1_nx, in2_nx} = vec_idx + 2'd1;
          end
        end else begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold_cnt <= '0;
      vec_idx <= '0;
      err_count <= '0;
      fail_vec <= '0;
      pass <= 1'b0;
      input1 <= 1'b0;
      input2 <= 1'b0;
    end else begin
      state <= state_nx;
      hold_cnt <= hold_nx;
      vec_idx <= vec_nx;
      err_count <= err_nx;
      fail_vec <= fv_nx;
      pass <= pass_nx;
      input1 <= in1_nx;
      input2 <= in2_nx;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gates_bist_ctrl.sv
// tb_gates_bist_ctrl: randomized fault-injection bench for gates_bist_ctrl.
// Two instances: HOLD=4/CNT_W=8 and HOLD=1/CNT_W=4 (saturation, back-to-back).
module tb_gates_bist_ctrl;

  localparam int H0 = 4;
  localparam int H1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [1:0] start;
  logic [1:0] in1, in2, busy, done, pass;
  logic [1:0][6:0] gout;
  logic [1:0][3:0] fv;
  logic [7:0] ec0;
  logic [3:0] ec1;
  logic [6:0] fmask [4];
  logic [6:0] gtab [4];

  int vecs = 0;
  int errs = 0;

  // Truth table rows {inv1,and2,or2,xor2,xnor2,nand2,nor2} for ab=00..11.
  initial begin
    gtab[0] = 7'b1000111;
    gtab[1] = 7'b1011010;
    gtab[2] = 7'b0011010;
    gtab[3] = 7'b0110100;
  end

  always_comb begin
    for (int d = 0; d < 2; d++)
      gout[d] = gtab[{in1[d], in2[d]}] ^ fmask[{in1[d], in2[d]}];
  end

  gates_bist_ctrl #(.HOLD_CYCLES(H0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .input1(in1[0]), .input2(in2[0]),
    .inv1(gout[0][6]), .and2(gout[0][5]), .or2(gout[0][4]),
    .xor2(gout[0][3]), .xnor2(gout[0][2]), .nand2(gout[0][1]),
    .nor2(gout[0][0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(ec0), .fail_vec(fv[0])
  );

  gates_bist_ctrl #(.HOLD_CYCLES(H1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .input1(in1[1]), .input2(in2[1]),
    .inv1(gout[1][6]), .and2(gout[1][5]), .or2(gout[1][4]),
    .xor2(gout[1][3]), .xnor2(gout[1][2]), .nand2(gout[1][1]),
    .nor2(gout[1][0]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(ec1), .fail_vec(fv[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ecnt(input int d);
    return (d != 0) ? 32'(ec1) : 32'(ec0);
  endfunction

  task automatic chk_idle(input int d);
    chk("idle_in", {30'd0, in1[d], in2[d]}, 0);
    chk("idle_busy", 32'(busy[d]), 0);
    chk("idle_done", 32'(done[d]), 0);
    chk("idle_pass", 32'(pass[d]), 0);
    chk("idle_err", ecnt(d), 0);
    chk("idle_fv", 32'(fv[d]), 0);
  endtask

  // One full run on instance d; the model sums fault bits per vector.
  task automatic run(input int d, input bit extra);
    int h, maxc, exp_err;
    logic [3:0] exp_fv;
    h = (d != 0) ? H1 : H0;
    maxc = (d != 0) ? 15 : 255;
    exp_err = 0;
    exp_fv = '0;
    for (int v = 0; v < 4; v++) begin
      exp_err += $countones(fmask[v]);
      exp_fv[v] = (fmask[v] != 7'd0);
    end
    if (exp_err > maxc) exp_err = maxc;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    for (int c = 0; c < 4 * h; c++) begin
      chk("run_busy", 32'(busy[d]), 1);
      chk("run_done", 32'(done[d]), 0);
      chk("run_vec", {30'd0, in1[d], in2[d]}, 32'(c / h));
      if (extra) start[d] = (c == 2 || c == 9);
      @(negedge clk);
    end
    start[d] = 1'b0;
    chk("end_done", 32'(done[d]), 1);
    chk("end_busy", 32'(busy[d]), 0);
    chk("end_pass", 32'(pass[d]), 32'(exp_err == 0));
    chk("end_err", ecnt(d), 32'(exp_err));
    chk("end_fv", 32'(fv[d]), 32'(exp_fv));
    @(negedge clk);
    chk("post_done", 32'(done[d]), 0);
    chk("post_busy", 32'(busy[d]), 0);
    chk("post_in", {30'd0, in1[d], in2[d]}, 3);
    chk("hold_err", ecnt(d), 32'(exp_err));
    chk("hold_pass", 32'(pass[d]), 32'(exp_err == 0));
  endtask

  task automatic set_mask(input logic [6:0] m);
    for (int v = 0; v < 4; v++) fmask[v] = m;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    start = '0;
    set_mask(7'd0);
    repeat (3) @(negedge clk);
    chk_idle(0);
    chk_idle(1);
    rst_n = 1'b1;

    run(0, 1'b0);

    fmask[3] = 7'b0100000;
    run(0, 1'b0);

    set_mask(7'h7f);
    run(0, 1'b0);
    run(1, 1'b0);

    set_mask(7'd0);
    run(0, 1'b1);

    // Abort mid-run after vector 0 has already logged errors.
    fmask[0] = 7'h7f;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_err", ecnt(0), 7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in", {30'd0, in1[0], in2[0]}, 0);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_done", 32'(done[0]), 0);
    chk("abort_err", ecnt(0), 0);
    chk("abort_fv", 32'(fv[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fmask[0] = 7'd0;
    @(negedge clk);
    chk("abort_nodone", 32'(done[0]), 0);
    run(0, 1'b0);

    // start tied high: 4 busy, 1 done, 1 idle per period on HOLD=1.
    set_mask(7'h7f);
    @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 18; c++) begin
      k = c % 6;
      chk("tie_busy", 32'(busy[1]), 32'(k < 4));
      chk("tie_done", 32'(done[1]), 32'(k == 4));
      if (k < 4) chk("tie_vec", {30'd0, in1[1], in2[1]}, 32'(k));
      if (k == 0 && c >= 6) chk("tie_clr", ecnt(1), 0);
      if (k == 4) begin
        if (c < 6) begin
          chk("tie_err0", ecnt(1), 15);
          chk("tie_pass0", 32'(pass[1]), 0);
          set_mask(7'd0);
        end else begin
          chk("tie_err", ecnt(1), 0);
          chk("tie_pass", 32'(pass[1]), 1);
        end
      end
      @(negedge clk);
    end
    start[1] = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      for (int v = 0; v < 4; v++)
        fmask[v] = ($urandom_range(0, 1) != 0) ? 7'($urandom) : 7'd0;
      run(int'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
